// File: rtl/key_schedule_expander_pkg.sv
// Shared AES definitions for the key-schedule slice: round-key type, round count,
// state encoding, S-box table and GF(2^8) helpers.
package key_schedule_expander_pkg;

  typedef logic [127:0] roundKey_t;

  localparam int AES128_ROUNDS = 10;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXPAND = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] sub_byte(input logic [7:0] b);
    return SBOX[b];
  endfunction

endpackage

// File: rtl/key_sub_word.sv
// Key-schedule core transform: RotWord, SubWord, then XOR of rcon into the top byte.
module key_sub_word
  import key_schedule_expander_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [7:0]  rcon_i,
  output logic [31:0] word_o
);

  logic [31:0] rot_word;

  assign rot_word = {word_i[23:0], word_i[31:24]};

  assign word_o = {sub_byte(rot_word[31:24]) ^ rcon_i,
                   sub_byte(rot_word[23:16]),
                   sub_byte(rot_word[15:8]),
                   sub_byte(rot_word[7:0])};

endmodule

// File: rtl/key_schedule_expander.sv
// Iterative AES-128 key expander: one round key per clock into a key file plus a stream port.
// Build option KEY_SCHED_REVERSE_READ_EN mirrors the read index (entry NUM_ROUNDS-rdIndex).
//
// state  | meaning
// IDLE   | no keys expanded since reset
// EXPAND | writing key[1..NUM_ROUNDS], one per clock
// DONE   | key file complete, held until the next start
module key_schedule_expander
  import key_schedule_expander_pkg::*;
#(
  parameter int NUM_ROUNDS = AES128_ROUNDS
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         start,
  input  logic [127:0] cipherKey,
  output logic         busy,
  output logic         keysValid,
  output logic [127:0] streamKey,
  output logic         streamValid,
  output logic [3:0]   streamIndex,
  input  logic [3:0]   rdIndex,
  output logic [127:0] rdKey
);

  localparam logic [3:0] LAST_IDX = 4'(NUM_ROUNDS);

  state_t      state_q;
  logic [3:0]  cnt_q;
  logic [7:0]  rcon_q;
  logic        busy_q;
  logic        keys_valid_q;
  logic        stream_valid_q;
  logic [3:0]  stream_index_q;
  roundKey_t   stream_key_q;
  roundKey_t   key_q [0:NUM_ROUNDS];

  logic [31:0] temp_d;
  roundKey_t   next_key_d;

  // The stream register always holds the previous round key, so it feeds the next step.
  key_sub_word u_sub_word (
    .word_i (stream_key_q[31:0]),
    .rcon_i (rcon_q),
    .word_o (temp_d)
  );

  assign next_key_d[127:96] = stream_key_q[127:96] ^ temp_d;
  assign next_key_d[95:64]  = stream_key_q[95:64]  ^ next_key_d[127:96];
  assign next_key_d[63:32]  = stream_key_q[63:32]  ^ next_key_d[95:64];
  assign next_key_d[31:0]   = stream_key_q[31:0]   ^ next_key_d[63:32];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      rcon_q         <= '0;
      busy_q         <= 1'b0;
      keys_valid_q   <= 1'b0;
      stream_valid_q <= 1'b0;
      stream_index_q <= '0;
      stream_key_q   <= '0;
      for (int i = 0; i <= NUM_ROUNDS; i++) key_q[i] <= '0;
    end else begin
      case (state_q)
        EXPAND: begin
          key_q[cnt_q]   <= next_key_d;
          stream_key_q   <= next_key_d;
          stream_index_q <= cnt_q;
          stream_valid_q <= 1'b1;
          rcon_q         <= xtime(rcon_q);
          cnt_q          <= cnt_q + 4'd1;
          if (cnt_q == LAST_IDX) begin
            state_q      <= DONE;
            busy_q       <= 1'b0;
            keys_valid_q <= 1'b1;
          end
        end
        default: begin
          stream_valid_q <= 1'b0;
          if (start) begin
            key_q[0]       <= cipherKey;
            stream_key_q   <= cipherKey;
            stream_index_q <= '0;
            stream_valid_q <= 1'b1;
            cnt_q          <= 4'd1;
            rcon_q         <= 8'h01;
            keys_valid_q   <= 1'b0;
            busy_q         <= 1'b1;
            state_q        <= EXPAND;
          end
        end
      endcase
    end
  end

  always_comb begin
    rdKey = '0;
    if (rdIndex <= LAST_IDX) begin
`ifdef KEY_SCHED_REVERSE_READ_EN
      rdKey = key_q[LAST_IDX - rdIndex];
`else
      rdKey = key_q[rdIndex];
`endif
    end
  end

  assign busy        = busy_q;
  assign keysValid   = keys_valid_q;
  assign streamKey   = stream_key_q;
  assign streamValid = stream_valid_q;
  assign streamIndex = stream_index_q;

endmodule

// File: tb/tb_key_schedule_expander.sv
// Directed bench for key_schedule_expander using FIPS-197 key-expansion vectors.
module tb_key_schedule_expander;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0;
  logic [127:0] cipherKey = '0;
  logic         busy;
  logic         keysValid;
  logic [127:0] streamKey;
  logic         streamValid;
  logic [3:0]   streamIndex;
  logic [3:0]   rdIndex = '0;
  logic [127:0] rdKey;

  int n_checks = 0;
  int n_pass   = 0;

  localparam logic [127:0] A1_KEY   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] A1_K1    = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] A1_K2    = 128'hf2c295f27a96b9435935807a7359f67f;
  localparam logic [127:0] A1_K10   = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] C1_KEY   = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_K10   = 128'h13111d7fe3944a17f307a78b4d2b30c5;
  localparam logic [127:0] Z_K1     = 128'h62636363626363636263636362636363;
  localparam logic [127:0] Z_K2     = 128'h9b9898c9f9fbfbaa9b9898c9f9fbfbaa;
  localparam logic [127:0] Z_K10    = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

`ifdef KEY_SCHED_REVERSE_READ_EN
  localparam bit REV = 1'b1;
`else
  localparam bit REV = 1'b0;
`endif

  logic [7:0] rcon_tab [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

  key_schedule_expander dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .cipherKey   (cipherKey),
    .busy        (busy),
    .keysValid   (keysValid),
    .streamKey   (streamKey),
    .streamValid (streamValid),
    .streamIndex (streamIndex),
    .rdIndex     (rdIndex),
    .rdKey       (rdKey)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, got, exp);
  endtask

  task automatic do_start(input logic [127:0] key);
    @(negedge clock);
    cipherKey = key;
    start     = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
  endtask

  task automatic run_expand(input string tag, input logic [127:0] key,
                            input logic [127:0] exp1, input logic [127:0] exp2,
                            input logic [127:0] exp10, input bit chk_mid, input bit chk_rcon);
    do_start(key);
    check({tag, "_s0_key"},   streamKey, key);
    check({tag, "_s0_valid"}, 128'(streamValid), 128'(1'b1));
    check({tag, "_s0_busy"},  128'(busy), 128'(1'b1));
    check({tag, "_s0_kv"},    128'(keysValid), 128'(1'b0));
    if (chk_rcon) check({tag, "_rcon0"}, 128'(dut.rcon_q), 128'(rcon_tab[0]));
    for (int k = 1; k <= 10; k++) begin
      @(posedge clock);
      #1;
      check($sformatf("%s_busy%0d", tag, k), 128'(busy), 128'(k < 10));
      check($sformatf("%s_kv%0d", tag, k),   128'(keysValid), 128'(k == 10));
      check($sformatf("%s_idx%0d", tag, k),  128'(streamIndex), 128'(k));
      check($sformatf("%s_sv%0d", tag, k),   128'(streamValid), 128'(1'b1));
      if (chk_mid && k == 1) check({tag, "_key1"}, streamKey, exp1);
      if (chk_mid && k == 2) check({tag, "_key2"}, streamKey, exp2);
      if (chk_rcon && k < 10)
        check($sformatf("%s_rcon%0d", tag, k), 128'(dut.rcon_q), 128'(rcon_tab[k]));
    end
    check({tag, "_key10"}, streamKey, exp10);
    @(posedge clock);
    #1;
    check({tag, "_done_sv"},   128'(streamValid), 128'(1'b0));
    check({tag, "_done_kv"},   128'(keysValid), 128'(1'b1));
    check({tag, "_done_busy"}, 128'(busy), 128'(1'b0));
  endtask

  initial begin
    #23;
    check("rst_busy", 128'(busy), 128'(1'b0));
    check("rst_kv",   128'(keysValid), 128'(1'b0));
    check("rst_sv",   128'(streamValid), 128'(1'b0));
    check("rst_skey", streamKey, '0);
    check("rst_sidx", 128'(streamIndex), '0);
    check("rst_rd0",  rdKey, '0);
    @(negedge clock);
    reset = 1'b1;

    // FIPS-197 A.1 key
    run_expand("a1", A1_KEY, A1_K1, A1_K2, A1_K10, 1'b1, 1'b0);
    rdIndex = REV ? 4'd0 : 4'd10;
    #1;
    check("a1_rd_k10", rdKey, A1_K10);

    // Appendix C.1 key, read-port boundaries
    run_expand("c1", C1_KEY, '0, '0, C1_K10, 1'b0, 1'b0);
    rdIndex = 4'd10;
    #1;
    check("c1_rd10", rdKey, REV ? C1_KEY : C1_K10);
    rdIndex = 4'd0;
    #1;
    check("c1_rd0", rdKey, REV ? C1_K10 : C1_KEY);
    rdIndex = 4'd11;
    #1;
    check("c1_rd11", rdKey, '0);
    rdIndex = 4'd15;
    #1;
    check("c1_rd15", rdKey, '0);

    // All-zero key with per-cycle rcon tracking
    run_expand("zero", '0, Z_K1, Z_K2, Z_K10, 1'b1, 1'b1);
    rdIndex = REV ? 4'd9 : 4'd1;
    #1;
    check("zero_rd_k1", rdKey, Z_K1);

    // Second start during expansion must be ignored
    do_start(A1_KEY);
    for (int k = 1; k <= 10; k++) begin
      @(negedge clock);
      if (k == 4) begin
        start     = 1'b1;
        cipherKey = '0;
      end
      @(posedge clock);
      #1;
      start = 1'b0;
      check($sformatf("ign_busy%0d", k), 128'(busy), 128'(k < 10));
    end
    check("ign_key10", streamKey, A1_K10);
    check("ign_kv",    128'(keysValid), 128'(1'b1));
    check("ign_idx",   128'(streamIndex), 128'(4'd10));

    // Asynchronous reset in the middle of an expansion
    do_start(A1_KEY);
    repeat (4) @(posedge clock);
    #2;
    rdIndex = REV ? 4'd7 : 4'd3;
    reset   = 1'b0;
    #1;
    check("mid_rst_busy", 128'(busy), 128'(1'b0));
    check("mid_rst_kv",   128'(keysValid), 128'(1'b0));
    check("mid_rst_sv",   128'(streamValid), 128'(1'b0));
    check("mid_rst_rd3",  rdKey, '0);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    check("post_rst_busy", 128'(busy), 128'(1'b0));
    run_expand("rerun", A1_KEY, A1_K1, A1_K2, A1_K10, 1'b1, 1'b0);

    // Index orientation of the read port
    rdIndex = 4'd0;
    #1;
    check("orient_rd0", rdKey, REV ? A1_K10 : A1_KEY);
    rdIndex = 4'd10;
    #1;
    check("orient_rd10", rdKey, REV ? A1_KEY : A1_K10);
    rdIndex = 4'd12;
    #1;
    check("orient_rd12", rdKey, '0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
